// File: rtl/conv_pkg.sv
// Shared geometry and scheduler state encoding for the 8x8 -> 6x6 3x3 convolution path.
package conv_pkg;
    localparam int IMG_DIM    = 8;
    localparam int KERNEL_DIM = 3;
    localparam int IN_BYTES   = IMG_DIM * IMG_DIM;
    localparam int OUT_WORDS  = (IMG_DIM - KERNEL_DIM + 1) * (IMG_DIM - KERNEL_DIM + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_RES,
        DRAIN,
        GAP,
        FIN
    } sched_state_t;
endpackage

// File: rtl/conv_watchdog.sv
// Cycle counter with synchronous clear and count enable; expired_o is high while the count is TIMEOUT-1.
// Single-cycle update; no flow control.
module conv_watchdog
    import conv_pkg::*;
#(
    parameter int TIMEOUT = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired_o = (cnt_q == CW'(TIMEOUT - 1));
endmodule

// File: rtl/conv_frame_scheduler.sv
// Sequences multi-frame jobs through the conv engine: 64-cycle load, watchdog-guarded wait, 36-cycle drain,
// one gap cycle between frames. Control outputs are registered; start is only honoured while idle.
module conv_frame_scheduler
    import conv_pkg::*;
#(
    parameter int FW      = 4,
    parameter int TIMEOUT = 256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [FW:0]   frame_count,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          in_ram_rd,
    output logic [FW+5:0] in_ram_addr,
    input  logic [7:0]    in_ram_rdata,
    output logic          conv_in_st,
    output logic [7:0]    conv_din,
    input  logic          conv_out_st,
    input  logic [15:0]   conv_dout,
    output logic          out_ram_we,
    output logic [FW+5:0] out_ram_addr,
    output logic [15:0]   out_ram_wdata
);
    localparam logic [5:0] LAST_BYTE = 6'(IN_BYTES - 1);
    localparam logic [5:0] LAST_WORD = 6'(OUT_WORDS - 1);

    sched_state_t  state_q;
    logic [FW:0]   nfrm_q, frm_q;
    logic [5:0]    cnt_q;
    logic [FW+5:0] in_ptr_q, out_ptr_q;
    logic          busy_q, done_q, err_q, rd_q, in_st_q, we_q;
    logic          wd_expired;

    conv_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (state_q == LOAD),
        .en_i      (state_q == WAIT_RES),
        .expired_o (wd_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            nfrm_q    <= '0;
            frm_q     <= '0;
            cnt_q     <= '0;
            in_ptr_q  <= '0;
            out_ptr_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            rd_q      <= 1'b0;
            in_st_q   <= 1'b0;
            we_q      <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            in_st_q <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    busy_q    <= 1'b1;
                    err_q     <= 1'b0;
                    nfrm_q    <= frame_count;
                    frm_q     <= '0;
                    cnt_q     <= '0;
                    in_ptr_q  <= '0;
                    out_ptr_q <= '0;
                    if (frame_count == '0) begin
                        done_q  <= 1'b1;
                        state_q <= FIN;
                    end else begin
                        rd_q    <= 1'b1;
                        in_st_q <= 1'b1;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    in_ptr_q <= in_ptr_q + 1'b1;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == LAST_BYTE) begin
                        rd_q    <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= WAIT_RES;
                    end
                end
                // A strobe on the watchdog's last cycle still wins over the abort.
                WAIT_RES: if (conv_out_st) begin
                    we_q    <= 1'b1;
                    cnt_q   <= '0;
                    state_q <= DRAIN;
                end else if (wd_expired) begin
                    err_q   <= 1'b1;
                    done_q  <= 1'b1;
                    state_q <= FIN;
                end
                DRAIN: begin
                    out_ptr_q <= out_ptr_q + 1'b1;
                    cnt_q     <= cnt_q + 1'b1;
                    if (cnt_q == LAST_WORD) begin
                        we_q  <= 1'b0;
                        cnt_q <= '0;
                        frm_q <= frm_q + 1'b1;
                        if ((frm_q + 1'b1) == nfrm_q) begin
                            done_q  <= 1'b1;
                            state_q <= FIN;
                        end else begin
                            state_q <= GAP;
                        end
                    end
                end
                GAP: begin
                    rd_q    <= 1'b1;
                    in_st_q <= 1'b1;
                    state_q <= LOAD;
                end
                FIN: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign in_ram_rd     = rd_q;
    assign in_ram_addr   = in_ptr_q;
    assign conv_in_st    = in_st_q;
    assign conv_din      = in_ram_rdata;
    assign out_ram_we    = we_q;
    assign out_ram_addr  = out_ptr_q;
    assign out_ram_wdata = we_q ? conv_dout : 16'h0000;
endmodule

// File: tb/tb_conv_frame_scheduler.sv
// Directed bench: RAM and Gaussian-kernel engine models around conv_frame_scheduler, checked per scenario.
module tb_conv_frame_scheduler;
    localparam int FW      = 4;
    localparam int TIMEOUT = 256;
    localparam int ENG_LAT = 5;

    logic          clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [FW:0]   frame_count = '0;
    logic          busy, done, err, in_ram_rd, conv_in_st, conv_out_st, out_ram_we;
    logic [FW+5:0] in_ram_addr, out_ram_addr;
    logic [7:0]    in_ram_rdata = 8'h00;
    logic [7:0]    conv_din;
    logic [15:0]   conv_dout = 16'h0000;
    logic [15:0]   out_ram_wdata;
    logic          eng_st = 1'b0, spur_st = 1'b0, eng_mute = 1'b0, eng_busy = 1'b0, mon_clr = 1'b0;

    int checks = 0, errors = 0, cyc = 0, start_cyc = 0, widx;
    int n_rd, n_inst, n_we, n_done, rd_seq_err, wr_seq_err, wr_data_err, gap_err;
    int exp_rd_addr, exp_wr_addr, last_rd_cyc, last_we_cyc, first_inst_cyc, done_cyc;
    logic done_err, done_busy;
    logic [15:0] exp_word [16];
    logic [7:0]  in_mem [1024];
    logic [7:0]  pix [64];
    logic [15:0] res [36];

    conv_frame_scheduler #(.FW(FW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .start(start), .frame_count(frame_count),
        .busy(busy), .done(done), .err(err),
        .in_ram_rd(in_ram_rd), .in_ram_addr(in_ram_addr), .in_ram_rdata(in_ram_rdata),
        .conv_in_st(conv_in_st), .conv_din(conv_din),
        .conv_out_st(conv_out_st), .conv_dout(conv_dout),
        .out_ram_we(out_ram_we), .out_ram_addr(out_ram_addr), .out_ram_wdata(out_ram_wdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (in_ram_rd) in_ram_rdata <= in_mem[in_ram_addr];
    assign conv_out_st = eng_st | spur_st;

    function automatic logic [15:0] conv_px(input int r, input int c);
        int s = 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                s += ((i == 1) ? 2 : 1) * ((j == 1) ? 2 : 1) * int'(pix[(r + i) * 8 + c + j]);
        return 16'(s);
    endfunction

    // Engine: samples 64 pixels after its load strobe, then strobes and streams 36 results.
    initial begin
        forever begin
            @(posedge clk);
            if (conv_in_st && !rst) begin
                eng_busy = 1'b1;
                for (int i = 0; i < 64; i++) begin @(posedge clk); pix[i] = conv_din; end
                if (!eng_mute) begin
                    for (int r = 0; r < 6; r++)
                        for (int c = 0; c < 6; c++) res[r * 6 + c] = conv_px(r, c);
                    repeat (ENG_LAT) @(posedge clk);
                    #1 eng_st = 1'b1;
                    @(posedge clk); #1 eng_st = 1'b0;
                    for (int k = 0; k < 36; k++) begin conv_dout = res[k]; @(posedge clk); #1; end
                    conv_dout = 16'h0000;
                end
                eng_busy = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (mon_clr) begin
            n_rd = 0; n_inst = 0; n_we = 0; n_done = 0; rd_seq_err = 0; wr_seq_err = 0;
            wr_data_err = 0; gap_err = 0; exp_rd_addr = 0; exp_wr_addr = 0; last_rd_cyc = 0;
            last_we_cyc = 0; first_inst_cyc = 0; done_cyc = 0; done_err = 1'b0; done_busy = 1'b0;
        end else begin
            if (in_ram_rd) begin
                if (int'(in_ram_addr) != exp_rd_addr) rd_seq_err++;
                exp_rd_addr++; n_rd++; last_rd_cyc = cyc;
            end
            if (conv_in_st) begin
                n_inst++;
                if (n_inst == 1) first_inst_cyc = cyc;
                else if (cyc - last_we_cyc != 2) gap_err++;
            end
            if (out_ram_we) begin
                if (int'(out_ram_addr) != exp_wr_addr) wr_seq_err++;
                widx = int'(out_ram_addr) / 36;
                if (widx > 15 || out_ram_wdata !== exp_word[widx]) wr_data_err++;
                exp_wr_addr++; n_we++; last_we_cyc = cyc;
            end
            if (done) begin n_done++; done_cyc = cyc; done_err = err; done_busy = busy; end
        end
    end

    task automatic tick();
        @(negedge clk); #1;
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1; tick(); mon_clr = 1'b0;
    endtask

    task automatic fill_frame(input int f, input logic [7:0] v);
        for (int i = 0; i < 64; i++) in_mem[f * 64 + i] = v;
        exp_word[f] = 16'(16 * int'(v));
    endtask

    task automatic launch(input int fc);
        frame_count = (FW+1)'(fc); start = 1'b1; start_cyc = cyc; tick(); start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        for (int i = 0; i < budget && n_done == 0; i++) tick();
        checks++; if (n_done == 0) begin errors++; $display("FAIL %s_done_wait: no done within %0d cycles", tag, budget); end
    endtask

    task automatic test_reset();
        repeat (3) tick();
        checks++; if ({busy, done, err, in_ram_rd, conv_in_st, out_ram_we} !== 6'b0) begin errors++; $display("FAIL reset_ctrl: got %b exp 000000", {busy, done, err, in_ram_rd, conv_in_st, out_ram_we}); end
        checks++; if (in_ram_addr !== '0 || out_ram_addr !== '0) begin errors++; $display("FAIL reset_addr: in %0d out %0d exp 0 0", in_ram_addr, out_ram_addr); end
        checks++; if (out_ram_wdata !== 16'h0000) begin errors++; $display("FAIL reset_wdata: got %h exp 0000", out_ram_wdata); end
        checks++; if (conv_din !== in_ram_rdata) begin errors++; $display("FAIL reset_din: got %h exp %h", conv_din, in_ram_rdata); end
        rst = 1'b0; tick();
    endtask

    task automatic test_one_frame();
        fill_frame(0, 8'h10);
        clear_mon(); launch(1); wait_done(400, "one"); repeat (3) tick();
        checks++; if (n_inst !== 1) begin errors++; $display("FAIL one_in_st_count: got %0d exp 1", n_inst); end
        checks++; if (first_inst_cyc !== start_cyc + 1) begin errors++; $display("FAIL one_load_start: got cyc %0d exp %0d", first_inst_cyc, start_cyc + 1); end
        checks++; if (n_rd !== 64 || rd_seq_err !== 0) begin errors++; $display("FAIL one_reads: got %0d reads %0d bad addr exp 64 0", n_rd, rd_seq_err); end
        checks++; if (n_we !== 36 || wr_seq_err !== 0) begin errors++; $display("FAIL one_writes: got %0d writes %0d bad addr exp 36 0", n_we, wr_seq_err); end
        checks++; if (wr_data_err !== 0) begin errors++; $display("FAIL one_wdata: got %0d bad words exp 0 (0x0100)", wr_data_err); end
        checks++; if (n_done !== 1 || done_err !== 1'b0 || done_busy !== 1'b1) begin errors++; $display("FAIL one_done: got n=%0d err=%b busy=%b exp 1 0 1", n_done, done_err, done_busy); end
        checks++; if (done_cyc !== last_we_cyc + 1) begin errors++; $display("FAIL one_done_timing: got %0d exp %0d", done_cyc, last_we_cyc + 1); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL one_busy_drop: got %b exp 0", busy); end
    endtask

    task automatic test_multi_frame();
        fill_frame(0, 8'h10); fill_frame(1, 8'h20); fill_frame(2, 8'h30);
        clear_mon(); launch(3); wait_done(1500, "multi"); repeat (3) tick();
        checks++; if (n_rd !== 192 || rd_seq_err !== 0) begin errors++; $display("FAIL multi_reads: got %0d reads %0d bad addr exp 192 0", n_rd, rd_seq_err); end
        checks++; if (n_we !== 108 || wr_seq_err !== 0) begin errors++; $display("FAIL multi_writes: got %0d writes %0d bad addr exp 108 0", n_we, wr_seq_err); end
        checks++; if (wr_data_err !== 0) begin errors++; $display("FAIL multi_wdata: got %0d bad words exp 0", wr_data_err); end
        checks++; if (n_inst !== 3 || gap_err !== 0) begin errors++; $display("FAIL multi_gap: got %0d loads %0d bad gaps exp 3 0", n_inst, gap_err); end
        checks++; if (n_done !== 1 || done_cyc !== last_we_cyc + 1) begin errors++; $display("FAIL multi_done: got n=%0d cyc=%0d exp 1 %0d", n_done, done_cyc, last_we_cyc + 1); end
    endtask

    task automatic test_zero_frames();
        clear_mon(); launch(0); wait_done(10, "zero"); repeat (3) tick();
        checks++; if (done_cyc !== start_cyc + 1 || n_done !== 1) begin errors++; $display("FAIL zero_done: got cyc=%0d n=%0d exp %0d 1", done_cyc, n_done, start_cyc + 1); end
        checks++; if (n_rd + n_we + n_inst !== 0) begin errors++; $display("FAIL zero_activity: got rd=%0d we=%0d st=%0d exp 0 0 0", n_rd, n_we, n_inst); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy: got %b exp 0", busy); end
    endtask

    task automatic test_timeout();
        eng_mute = 1'b1;
        clear_mon(); launch(2); wait_done(800, "tmo"); repeat (3) tick();
        checks++; if (done_cyc !== last_rd_cyc + 1 + TIMEOUT) begin errors++; $display("FAIL tmo_done_timing: got %0d exp %0d", done_cyc, last_rd_cyc + 1 + TIMEOUT); end
        checks++; if (done_err !== 1'b1 || err !== 1'b1) begin errors++; $display("FAIL tmo_err: got at_done=%b now=%b exp 1 1", done_err, err); end
        checks++; if (n_we !== 0 || n_rd !== 64 || n_inst !== 1) begin errors++; $display("FAIL tmo_abandon: got we=%0d rd=%0d st=%0d exp 0 64 1", n_we, n_rd, n_inst); end
        eng_mute = 1'b0;
        for (int i = 0; i < 100 && eng_busy; i++) tick();
        clear_mon(); launch(1);
        checks++; if (err !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL tmo_err_clear: got err=%b busy=%b exp 0 1", err, busy); end
        wait_done(400, "tmo_next"); repeat (3) tick();
        checks++; if (n_we !== 36 || done_err !== 1'b0) begin errors++; $display("FAIL tmo_next_job: got we=%0d err=%b exp 36 0", n_we, done_err); end
    endtask

    task automatic test_spurious();
        clear_mon(); launch(1);
        repeat (10) tick();
        spur_st = 1'b1; tick(); spur_st = 1'b0;
        for (int i = 0; i < 300 && !out_ram_we; i++) tick();
        checks++; if (out_ram_we !== 1'b1) begin errors++; $display("FAIL spur_drain_wait: got we=%b exp 1", out_ram_we); end
        repeat (5) tick();
        launch(7); wait_done(300, "spur"); repeat (10) tick();
        checks++; if (n_rd !== 64 || rd_seq_err !== 0 || n_inst !== 1) begin errors++; $display("FAIL spur_load: got rd=%0d bad=%0d st=%0d exp 64 0 1", n_rd, rd_seq_err, n_inst); end
        checks++; if (n_we !== 36 || wr_seq_err !== 0 || wr_data_err !== 0) begin errors++; $display("FAIL spur_drain: got we=%0d badaddr=%0d baddata=%0d exp 36 0 0", n_we, wr_seq_err, wr_data_err); end
        checks++; if (n_done !== 1 || busy !== 1'b0 || done_cyc !== last_we_cyc + 1) begin errors++; $display("FAIL spur_done: got n=%0d busy=%b cyc=%0d exp 1 0 %0d", n_done, busy, done_cyc, last_we_cyc + 1); end
    endtask

    task automatic test_rst_mid_drain();
        fill_frame(0, 8'h10); fill_frame(1, 8'h20);
        clear_mon(); launch(2);
        for (int i = 0; i < 600 && !(out_ram_we && out_ram_addr == 50); i++) tick();
        checks++; if (out_ram_we !== 1'b1 || out_ram_addr !== 10'd50) begin errors++; $display("FAIL rst_reach_drain: got we=%b addr=%0d exp 1 50", out_ram_we, out_ram_addr); end
        rst = 1'b1; #1;
        checks++; if ({busy, done, err, in_ram_rd, conv_in_st, out_ram_we} !== 6'b0) begin errors++; $display("FAIL rst_async_ctrl: got %b exp 000000", {busy, done, err, in_ram_rd, conv_in_st, out_ram_we}); end
        checks++; if (in_ram_addr !== '0 || out_ram_addr !== '0 || out_ram_wdata !== 16'h0000) begin errors++; $display("FAIL rst_async_data: in=%0d out=%0d wd=%h exp 0 0 0000", in_ram_addr, out_ram_addr, out_ram_wdata); end
        checks++; if (dut.state_q !== conv_pkg::IDLE) begin errors++; $display("FAIL rst_state: got %0d exp IDLE", dut.state_q); end
        tick(); rst = 1'b0;
        for (int i = 0; i < 100 && eng_busy; i++) tick();
        clear_mon(); launch(1); wait_done(400, "rst_restart"); repeat (3) tick();
        checks++; if (n_rd !== 64 || rd_seq_err !== 0) begin errors++; $display("FAIL rst_restart_reads: got %0d reads %0d bad addr exp 64 0", n_rd, rd_seq_err); end
        checks++; if (n_we !== 36 || wr_seq_err !== 0 || wr_data_err !== 0) begin errors++; $display("FAIL rst_restart_writes: got we=%0d badaddr=%0d baddata=%0d exp 36 0 0", n_we, wr_seq_err, wr_data_err); end
    endtask

    initial begin
        test_reset();
        test_one_frame();
        test_multi_frame();
        test_zero_frames();
        test_timeout();
        test_spurious();
        test_rst_mid_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "time limit");
    end
endmodule

// File: doc/conv_frame_scheduler.md
# conv_frame_scheduler

Sequences multi-frame 2D convolution jobs through the single 8x8→6x6 3x3 convolution engine. On a host `start`, it streams each 64-byte input frame from the input-feature RAM into the engine, waits for the engine's result strobe under a watchdog, and writes the 36 16-bit results into the output RAM. It sits between the host/testbench control, the two RAMs, and the convolution engine, and owns all engine handshakes.

## Interface
- `FW`, 4: frame-index width; up to 2^FW frames per job.
- `TIMEOUT`, 256: maximum cycles spent in WAIT_RES before the job is aborted.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle job request; sampled only in IDLE.
- `frame_count`  in  FW+1  frames in the job, latched on accepted `start`.
- `busy`  out  1  high from accepted `start` until the `done` cycle, inclusive.
- `done`  out  1  one-cycle pulse at end of job.
- `err`  out  1  sticky watchdog error; cleared on the next accepted `start`.
- `in_ram_rd`  out  1  input RAM read enable.
- `in_ram_addr`  out  FW+6  input RAM byte address.
- `in_ram_rdata`  in  8  read data, valid the cycle after `in_ram_rd`.
- `conv_in_st`  out  1  engine load strobe.
- `conv_din`  out  8  engine pixel input; combinationally equal to `in_ram_rdata`.
- `conv_out_st`  in  1  engine result strobe.
- `conv_dout`  in  16  engine result, the k-th word valid on the k-th cycle after `conv_out_st`, k=1..36.
- `out_ram_we`  out  1  output RAM write enable.
- `out_ram_addr`  out  FW+6  output RAM word address.
- `out_ram_wdata`  out  16  write data.

## Operation
- States: IDLE, LOAD, WAIT_RES, DRAIN, GAP, FIN.
- IDLE: on `start`, latch `frame_count`, clear `err`, zero `frm`, `in_ptr`, and `out_ptr`. If `frame_count`==0, go to FIN; otherwise go to LOAD.
- LOAD, 64 cycles, byte counter `k`=0..63:
  - `in_ram_rd`=1 and `in_ram_addr`=`in_ptr` every cycle; `in_ptr` increments each cycle.
  - `conv_in_st`=1 only when `k`=0.
  - After `k`=63, go to WAIT_RES and clear the watchdog.
- WAIT_RES: the watchdog increments each cycle.
  - `conv_out_st`=1 → go to DRAIN with `j`=0.
  - Watchdog reaches TIMEOUT-1 without the strobe → set `err` and go to FIN, abandoning the remaining frames.
- DRAIN, 36 cycles:
  - `out_ram_we`=1, `out_ram_wdata`=`conv_dout`, `out_ram_addr`=`out_ptr`; `out_ptr` increments.
  - After `j`=35, increment `frm`. If `frm`==`frame_count`, go to FIN; otherwise go to GAP.
- GAP: one idle cycle so the engine's output sequencer can finish; then go to LOAD.
- FIN: `done`=1 for one cycle; `busy` drops on the following cycle; go to IDLE.
- Addressing: frame f occupies input bytes 64f..64f+63 and output words 36f..36f+35. Both come from running pointers; there are no multipliers.
- `conv_out_st` is ignored in every state except WAIT_RES. `start` is ignored while `busy`.
- `rst` mid-job: immediate return to IDLE, all outputs 0, `err` cleared. Engine internal state is not reset by this block; the engine is reset at system level.

## Timing
- Reset values: `busy`, `done`, `err`, `in_ram_rd`, `conv_in_st`, and `out_ram_we` are 0. `in_ram_addr`, `out_ram_addr`, and `out_ram_wdata` are 0. `conv_din` follows `in_ram_rdata`.
- All control outputs are registered-state decodes; no combinational path from `start` to outputs.
- LOAD alignment:
  - `conv_in_st` and the first read occur in the same cycle P.
  - Byte k reaches `conv_din` in cycle P+1+k, which matches the engine's sampling.
- Accepted `start` at cycle T: LOAD begins at T+1.
- Per-frame overhead excluding engine compute: 64 LOAD + 36 DRAIN + 1 GAP cycles, plus WAIT_RES time.
- Job end: `done` occurs in the cycle after the last DRAIN write.

## Structure
- Shared package `conv_pkg`:
  - constants IN_BYTES=64, OUT_WORDS=36, and KERNEL_DIM=3;
  - the state enum `sched_state_t`.
- One sub-module: `conv_watchdog`, a loadable counter with clear/enable and a `expired` output at TIMEOUT-1.
- Everything else is a single FSM plus the `k`/`j`, `in_ptr`, `out_ptr`, and `frm` counters.

## Test plan
- One frame, input bytes 0..63 = 0x10, with a behavioural engine model:
  - `conv_in_st` in exactly one cycle; 64 consecutive reads at addresses 0..63;
  - 36 writes at addresses 0..35 with data 0x0100;
  - `done` exactly once; `err`=0.
- `frame_count`=3: input addresses run 0..191 and output addresses run 0..107 with no gaps or duplicates; exactly one GAP cycle between DRAIN and the next LOAD; 3 `conv_in_st` pulses.
- `frame_count`=0: `done` at T+1 with no RAM or engine activity.
- Engine model never strobes: `err`=1 and `done` exactly TIMEOUT cycles after WAIT_RES entry; no output writes; the next `start` clears `err`.
- Spurious `conv_out_st` during LOAD, and `start` pulsed during DRAIN: both have no effect, and the frame completes normally.
- `rst` asserted mid-DRAIN of frame 1 of 2:
  - all outputs are 0 asynchronously; state is IDLE;
  - a following `start` with `frame_count`=1 restarts from address 0.
